// File: rtl/alu_exec_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_exec_unit_pkg
//  Description : Shared constants for the execute-stage ALU. The ALU_CTL_*
//                and ALU_SHIFT_* codes are the ones produced by the ALU
//                control decoder. The EXU_ST_* codes are the execute-unit
//                FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_exec_unit_pkg;

    // ALU control codes
    localparam logic [2:0] ALU_CTL_ADD      = 3'd0;
    localparam logic [2:0] ALU_CTL_SUB      = 3'd1;
    localparam logic [2:0] ALU_CTL_AND      = 3'd2;
    localparam logic [2:0] ALU_CTL_OR       = 3'd3;
    localparam logic [2:0] ALU_CTL_XOR      = 3'd4;
    localparam logic [2:0] ALU_CTL_LESS_SIG = 3'd5;
    localparam logic [2:0] ALU_CTL_LESS_UNS = 3'd6;
    localparam logic [2:0] ALU_CTL_SHIFT    = 3'd7;

    // Shift selector codes; only meaningful with ALU_CTL_SHIFT
    localparam logic [1:0] ALU_SHIFT_NONE   = 2'b00;
    localparam logic [1:0] ALU_SHIFT_SLL    = 2'b01;
    localparam logic [1:0] ALU_SHIFT_SRL    = 2'b10;
    localparam logic [1:0] ALU_SHIFT_SRA    = 2'b11;

    // Execute-unit FSM state codes
    typedef enum logic [1:0] {
        EXU_ST_IDLE  = 2'd0,
        EXU_ST_SHIFT = 2'd1,
        EXU_ST_DONE  = 2'd2
    } exu_state_t;

endpackage : alu_exec_unit_pkg
`default_nettype wire

// File: rtl/alu_comb_core.sv
`default_nettype none
// ============================================================================
//  Module      : alu_comb_core
//  Description : Purely combinational evaluation of the single-cycle ALU
//                operations. Codes without a single-cycle meaning (including
//                the shift code, which is handled serially upstream) give 0.
//  Ports       : i_alu_ctl  - ALU control code
//                i_op_a     - operand A
//                i_op_b     - operand B
//                o_result   - operation result
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_comb_core
    import alu_exec_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       i_alu_ctl,
    input  logic [WIDTH-1:0] i_op_a,
    input  logic [WIDTH-1:0] i_op_b,
    output logic [WIDTH-1:0] o_result
);

    always_comb begin
        o_result = '0;
        case (i_alu_ctl)
            ALU_CTL_ADD:      o_result = i_op_a + i_op_b;
            ALU_CTL_SUB:      o_result = i_op_a - i_op_b;
            ALU_CTL_AND:      o_result = i_op_a & i_op_b;
            ALU_CTL_OR:       o_result = i_op_a | i_op_b;
            ALU_CTL_XOR:      o_result = i_op_a ^ i_op_b;
            ALU_CTL_LESS_SIG: o_result = {{(WIDTH-1){1'b0}}, ($signed(i_op_a) < $signed(i_op_b))};
            ALU_CTL_LESS_UNS: o_result = {{(WIDTH-1){1'b0}}, (i_op_a < i_op_b)};
            default:          o_result = '0;
        endcase
    end

endmodule : alu_comb_core
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module      : alu_exec_unit
//  Description : Execute-stage ALU between ID/EX and EX/MEM. Single-cycle
//                ops finish one cycle after acceptance; shifts run serially,
//                one bit position per cycle. The result is held under
//                downstream backpressure, and a flush discards any in-flight
//                or held operation.
//  Ports       : i_clk, i_rst_n         - clock, async active-low reset
//                i_valid / o_ready      - request handshake
//                i_alu_ctl, i_alu_shift - operation select
//                i_op_a, i_op_b         - operands (b[SHAMT_W-1:0] = shamt)
//                i_flush                - synchronous pipeline flush
//                o_valid / i_ready      - result handshake
//                o_result, o_zero       - result and zero flag
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_unit
    import alu_exec_unit_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [2:0]         i_alu_ctl,
    input  logic [1:0]         i_alu_shift,
    input  logic [WIDTH-1:0]   i_op_a,
    input  logic [WIDTH-1:0]   i_op_b,
    input  logic               i_flush,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [WIDTH-1:0]   o_result,
    output logic               o_zero
);

    exu_state_t           r_state;
    logic [WIDTH-1:0]     r_acc;
    logic [SHAMT_W-1:0]   r_cnt;
    logic [1:0]           r_mode;
    logic                 r_valid;

    logic [WIDTH-1:0]     w_core_result;
    logic [WIDTH-1:0]     w_shift_next;
    logic [SHAMT_W-1:0]   w_shamt;
    logic                 w_accept;
    logic                 w_shift_direct;

    alu_comb_core #(
        .WIDTH (WIDTH)
    ) u_alu_comb_core (
        .i_alu_ctl (i_alu_ctl),
        .i_op_a    (i_op_a),
        .i_op_b    (i_op_b),
        .o_result  (w_core_result)
    );

    // A held result frees the unit in the same cycle it is consumed, which
    // gives back-to-back throughput without a bubble.
    assign o_ready  = !i_flush &&
                      ((r_state == EXU_ST_IDLE) || ((r_state == EXU_ST_DONE) && i_ready));
    assign w_accept = i_valid && o_ready;
    assign w_shamt  = i_op_b[SHAMT_W-1:0];

    // Zero shift amount or "no shift" selector completes like a single-cycle op
    assign w_shift_direct = (w_shamt == '0) || (i_alu_shift == ALU_SHIFT_NONE);

    // One-bit step of the serial shifter
    always_comb begin
        w_shift_next = r_acc;
        case (r_mode)
            ALU_SHIFT_SLL: w_shift_next = {r_acc[WIDTH-2:0], 1'b0};
            ALU_SHIFT_SRL: w_shift_next = {1'b0, r_acc[WIDTH-1:1]};
            ALU_SHIFT_SRA: w_shift_next = {r_acc[WIDTH-1], r_acc[WIDTH-1:1]};
            default:       w_shift_next = r_acc;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= EXU_ST_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_mode  <= '0;
            r_valid <= 1'b0;
        end else if (i_flush) begin
            // Flush outranks everything, including a pending accept
            r_state <= EXU_ST_IDLE;
            r_valid <= 1'b0;
        end else if (w_accept) begin
            if (i_alu_ctl == ALU_CTL_SHIFT) begin
                r_acc  <= i_op_a;
                r_cnt  <= w_shamt;
                r_mode <= i_alu_shift;
                if (w_shift_direct) begin
                    r_state <= EXU_ST_DONE;
                    r_valid <= 1'b1;
                end else begin
                    r_state <= EXU_ST_SHIFT;
                    r_valid <= 1'b0;
                end
            end else begin
                r_acc   <= w_core_result;
                r_state <= EXU_ST_DONE;
                r_valid <= 1'b1;
            end
        end else begin
            case (r_state)
                EXU_ST_SHIFT: begin
                    r_acc <= w_shift_next;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == {{(SHAMT_W-1){1'b0}}, 1'b1}) begin
                        r_state <= EXU_ST_DONE;
                        r_valid <= 1'b1;
                    end
                end
                EXU_ST_DONE: begin
                    if (i_ready) begin
                        r_state <= EXU_ST_IDLE;
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= EXU_ST_IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_valid  = r_valid;
    assign o_result = r_acc;
    assign o_zero   = r_valid && (r_acc == '0);

endmodule : alu_exec_unit
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_exec_unit
//  Description : Self-checking bench for alu_exec_unit. Directed requests are
//                issued from one initial block; expected results and
//                latencies are queued at acceptance and checked by a monitor
//                when the DUT presents them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;
    import alu_exec_unit_pkg::*;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [2:0]  i_alu_ctl;
    logic [1:0]  i_alu_shift;
    logic [31:0] i_op_a;
    logic [31:0] i_op_b;
    logic        i_flush;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_result;
    logic        o_zero;

    alu_exec_unit #(
        .WIDTH   (32),
        .SHAMT_W (5)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_alu_ctl   (i_alu_ctl),
        .i_alu_shift (i_alu_shift),
        .i_op_a      (i_op_a),
        .i_op_b      (i_op_b),
        .i_flush     (i_flush),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_result    (o_result),
        .o_zero      (o_zero)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          acc_cyc;
    } exp_t;

    exp_t q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    bit   seen        = 1'b0;

    always @(posedge i_clk) cyc <= cyc + 1;

    // Reference behaviour of one operation
    function automatic logic [31:0] model(input logic [2:0] ctl, input logic [1:0] sh,
                                          input logic [31:0] a, input logic [31:0] b);
        logic [4:0] s;
        s = b[4:0];
        case (ctl)
            ALU_CTL_ADD:      return a + b;
            ALU_CTL_SUB:      return a - b;
            ALU_CTL_AND:      return a & b;
            ALU_CTL_OR:       return a | b;
            ALU_CTL_XOR:      return a ^ b;
            ALU_CTL_LESS_SIG: return {31'd0, ($signed(a) < $signed(b))};
            ALU_CTL_LESS_UNS: return {31'd0, (a < b)};
            ALU_CTL_SHIFT: begin
                case (sh)
                    ALU_SHIFT_SLL: return a << s;
                    ALU_SHIFT_SRL: return a >> s;
                    ALU_SHIFT_SRA: return $signed(a) >>> s;
                    default:       return a;
                endcase
            end
            default:          return 32'd0;
        endcase
    endfunction

    // Cycle (relative to the accept cycle 0) in which o_valid first rises
    function automatic int model_lat(input logic [2:0] ctl, input logic [1:0] sh,
                                     input logic [31:0] b);
        if (ctl == ALU_CTL_SHIFT && sh != ALU_SHIFT_NONE && b[4:0] != 5'd0)
            return int'(b[4:0]) + 1;
        return 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge
    task automatic send(input logic [2:0] ctl, input logic [1:0] sh,
                        input logic [31:0] a, input logic [31:0] b, input bit push);
        bit done;
        done        = 1'b0;
        i_valid     = 1'b1;
        i_alu_ctl   = ctl;
        i_alu_shift = sh;
        i_op_a      = a;
        i_op_b      = b;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge i_clk);
            if (o_ready) begin
                @(posedge i_clk);
                #1;
                done = 1'b1;
            end
        end
        i_valid = 1'b0;
        chk("accept", {31'd0, done}, 32'd1);
        if (done && push)
            q.push_back('{model(ctl, sh, a, b), model_lat(ctl, sh, b), cyc});
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && q.size() != 0; k++) @(negedge i_clk);
        @(posedge i_clk);
        #1;
        chk("drain_empty", q.size(), 32'd0);
    endtask

    // Result monitor: latency on first appearance, value on handshake
    always @(negedge i_clk) begin
        if (i_rst_n && o_valid) begin
            vectors++;
            assert (q.size() != 0) else begin
                miscompares++;
                $error("FAIL unexpected_valid: observed result %h expected no result", o_result);
            end
            if (q.size() != 0) begin
                if (!seen) begin
                    seen = 1'b1;
                    vectors++;
                    assert ((cyc - q[0].acc_cyc + 1) == q[0].lat) else begin
                        miscompares++;
                        $error("FAIL latency: observed %0d expected %0d",
                               cyc - q[0].acc_cyc + 1, q[0].lat);
                    end
                end
                if (i_ready && !i_flush) begin
                    vectors++;
                    assert (o_result === q[0].res) else begin
                        miscompares++;
                        $error("FAIL result: observed %h expected %h", o_result, q[0].res);
                    end
                    vectors++;
                    assert (o_zero === (q[0].res == 32'd0)) else begin
                        miscompares++;
                        $error("FAIL zero: observed %b expected %b", o_zero, (q[0].res == 32'd0));
                    end
                    void'(q.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt_hi;
        int rel_cyc;
        i_rst_n     = 1'b0;
        i_valid     = 1'b0;
        i_alu_ctl   = 3'd0;
        i_alu_shift = 2'd0;
        i_op_a      = 32'd0;
        i_op_b      = 32'd0;
        i_flush     = 1'b0;
        i_ready     = 1'b1;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        chk("rst_valid",  {31'd0, o_valid}, 32'd0);
        chk("rst_result", o_result,         32'd0);
        chk("rst_zero",   {31'd0, o_zero},  32'd0);
        chk("rst_ready",  {31'd0, o_ready}, 32'd1);
        @(posedge i_clk);
        #1;

        // Overflowing add followed back-to-back by a zero-result subtract
        send(ALU_CTL_ADD, ALU_SHIFT_NONE, 32'h7FFF_FFFF, 32'd1, 1'b1);
        send(ALU_CTL_SUB, ALU_SHIFT_NONE, 32'd5, 32'd5, 1'b1);
        // Signed vs unsigned compare
        send(ALU_CTL_LESS_SIG, ALU_SHIFT_NONE, 32'hFFFF_FFFF, 32'd1, 1'b1);
        send(ALU_CTL_LESS_UNS, ALU_SHIFT_NONE, 32'hFFFF_FFFF, 32'd1, 1'b1);
        send(ALU_CTL_AND, ALU_SHIFT_NONE, 32'hF0F0_1234, 32'h0FF0_FF00, 1'b1);
        send(ALU_CTL_OR,  ALU_SHIFT_NONE, 32'hA000_0005, 32'h0500_0050, 1'b1);
        send(ALU_CTL_XOR, ALU_SHIFT_NONE, 32'hDEAD_BEEF, 32'hFFFF_0000, 1'b1);
        drain();

        // Longest arithmetic shift; unit must stay busy throughout
        send(ALU_CTL_SHIFT, ALU_SHIFT_SRA, 32'h8000_0000, 32'd31, 1'b1);
        cnt_hi = 0;
        for (int i = 0; i < 31; i++) begin
            @(negedge i_clk);
            cnt_hi += int'(o_ready);
        end
        chk("sra_ready_low", cnt_hi, 32'd0);
        drain();
        send(ALU_CTL_SHIFT, ALU_SHIFT_SRL, 32'h8000_0000, 32'd31, 1'b1);
        drain();
        send(ALU_CTL_SHIFT, ALU_SHIFT_SLL, 32'd1, 32'd4, 1'b1);
        drain();
        // Shift amount field is zero (bit 5 outside the field)
        send(ALU_CTL_SHIFT, ALU_SHIFT_SLL, 32'hDEAD_BEEF, 32'h20, 1'b1);
        drain();

        // Backpressure: result held, pending request waits, then taken at once
        i_ready = 1'b0;
        send(ALU_CTL_XOR, ALU_SHIFT_NONE, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1);
        i_valid   = 1'b1;
        i_alu_ctl = ALU_CTL_ADD;
        i_op_a    = 32'd3;
        i_op_b    = 32'd4;
        for (int i = 0; i < 5; i++) begin
            @(negedge i_clk);
            chk("bp_valid",  {31'd0, o_valid}, 32'd1);
            chk("bp_result", o_result,         32'h0FF0_0FF0);
            chk("bp_ready",  {31'd0, o_ready}, 32'd0);
        end
        @(posedge i_clk);
        #1;
        i_ready = 1'b1;
        @(negedge i_clk);
        chk("bp_release_ready", {31'd0, o_ready}, 32'd1);
        @(posedge i_clk);
        #1;
        q.push_back('{32'd7, 1, cyc});
        i_valid = 1'b0;
        drain();

        // Flush in the middle of a 10-bit left shift
        send(ALU_CTL_SHIFT, ALU_SHIFT_SLL, 32'd1, 32'd10, 1'b0);
        repeat (3) @(posedge i_clk);
        #1;
        i_flush = 1'b1;
        @(negedge i_clk);
        chk("flush_blocks_ready", {31'd0, o_ready}, 32'd0);
        @(posedge i_clk);
        #1;
        i_flush = 1'b0;
        @(negedge i_clk);
        chk("flush_ready_after", {31'd0, o_ready}, 32'd1);
        cnt_hi = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge i_clk);
            cnt_hi += int'(o_valid);
        end
        chk("flush_no_valid", cnt_hi, 32'd0);
        @(posedge i_clk);
        #1;

        // Asynchronous reset in the middle of a shift
        send(ALU_CTL_SHIFT, ALU_SHIFT_SRL, 32'hF000_0000, 32'd20, 1'b0);
        repeat (5) @(posedge i_clk);
        #3;
        i_rst_n = 1'b0;
        #1;
        chk("arst_valid",  {31'd0, o_valid}, 32'd0);
        chk("arst_result", o_result,         32'd0);
        chk("arst_zero",   {31'd0, o_zero},  32'd0);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        rel_cyc = cyc;
        send(ALU_CTL_ADD, ALU_SHIFT_NONE, 32'h1234_0000, 32'h0000_5678, 1'b1);
        chk("arst_first_accept", cyc, rel_cyc + 1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_alu_exec_unit
`default_nettype wire

// File: doc/alu_exec_unit.md
# alu_exec_unit

Execute-stage arithmetic unit that consumes the 3-bit ALU control code and 2-bit shift selector produced by the ALU control decoder and performs the operation on two operands. Single-cycle ops (add, sub, and, or, xor, signed/unsigned less-than) complete in one cycle. Shifts execute serially, one bit position per cycle. The unit sits between ID/EX and EX/MEM. It uses valid/ready handshakes on both sides and holds its result until the consumer accepts it.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width
- `SHAMT_W`, 5, shift-amount width (log2 WIDTH)

Ports:
- `i_clk`  in  1  clock
- `i_rst_n`  in  1  reset; asynchronous, active-low. One clock domain.
- `i_valid`  in  1  operation request valid
- `o_ready`  out  1  unit can accept a request this cycle
- `i_alu_ctl`  in  3  `ALU_CTL_*` code
- `i_alu_shift`  in  2  `ALU_SHIFT_*` code; meaningful only when ctl is `ALU_CTL_SHIFT`
- `i_op_a`  in  WIDTH  operand A (value being shifted for shifts)
- `i_op_b`  in  WIDTH  operand B; bits [SHAMT_W-1:0] give the shift amount
- `i_flush`  in  1  synchronous pipeline flush
- `o_valid`  out  1  result valid
- `i_ready`  in  1  downstream accepts the result
- `o_result`  out  WIDTH  result
- `o_zero`  out  1  `o_valid & (o_result == 0)`; used for beq/bne

## Operation
- States: IDLE, SHIFT, DONE. Registers: `acc` (WIDTH), `cnt` (SHAMT_W), `mode` (2).
- Accept = `i_valid & o_ready`.
- `o_ready = !i_flush & (state==IDLE | (state==DONE & i_ready))`.
- On accept, non-shift ctl: `acc` <= combinational result; next state DONE.
  - ADD: a+b, mod 2^WIDTH.
  - SUB: a-b, mod 2^WIDTH.
  - AND, OR, XOR: bitwise.
  - LESS_SIG: {0…, $signed(a)<$signed(b)}.
  - LESS_UNS: {0…, a<b}.
  - Undefined codes give 0.
- On accept, `ALU_CTL_SHIFT`: `acc`<=a, `cnt`<=b[SHAMT_W-1:0], `mode`<=i_alu_shift.
  - If cnt==0 or mode==2'b00: go to DONE (result = a).
  - Otherwise: go to SHIFT.
- In SHIFT, each cycle:
  - SLL: acc<<1.
  - SRL: acc>>1, zero fill.
  - SRA: acc>>1, replicating acc[WIDTH-1].
  - cnt<=cnt-1. When cnt==1, go to DONE.
- DONE: `o_valid`=1, `o_result`=acc.
  - `i_ready` with no new accept: go to IDLE.
  - `i_ready` with a simultaneous accept: the new op is loaded per the rules above, giving back-to-back throughput.
- `i_flush` has the highest priority. It moves the unit to IDLE from any state, discards any in-flight shift or held result, and blocks acceptance that cycle. `o_valid` falls the following cycle.
- Reset: state IDLE, acc 0, cnt 0, mode 0. Outputs at reset: `o_valid`=0, `o_result`=0, `o_zero`=0, `o_ready`=1 (reset deasserted, no flush).
- `o_result` equals acc in all states. It is only meaningful when `o_valid` is high.

## Timing
- Accept in cycle 0. A non-shift op, or a shift by 0, gives `o_valid` in cycle 1.
- A shift by n (1..WIDTH-1) gives `o_valid` in cycle n+1.
- `o_ready` is low during SHIFT. `o_ready` is also low in DONE while `i_ready` is low.
- `o_valid`, `o_result` and `o_zero` stay stable while `o_valid & !i_ready` (backpressure hold).
- Reset asserted mid-shift clears the unit immediately (asynchronously); a fresh accept is possible on the first edge after release.
- Flush arriving in the same cycle as `i_valid` drops the request. Flush arriving in the same cycle as completion drops the result.

## Structure
- Shared constants header:
  - `ALU_CTL_*` and `ALU_SHIFT_*` are reused unchanged.
  - Add `EXU_ST_IDLE`/`EXU_ST_SHIFT`/`EXU_ST_DONE` as 2-bit state codes.
- Sub-module `alu_comb_core`: purely combinational single-cycle op evaluation (ctl, a, b → result). Instantiated once.
- The FSM, serial shifter and handshakes live in `alu_exec_unit`.

## Test plan
- ADD a=0x7FFFFFFF, b=1, `i_ready`=1. Expect `o_valid` in cycle 1, result 0x80000000, `o_zero`=0. Then SUB a=5, b=5. Expect result 0, `o_zero`=1, accepted back-to-back with no bubble.
- LESS_SIG a=0xFFFFFFFF, b=1: result 1. LESS_UNS with the same operands: result 0.
- SRA a=0x80000000, b=31: `o_ready` low for 31 cycles, `o_valid` in cycle 32, result 0xFFFFFFFF. SRL with the same inputs: result 0x00000001. SLL a=1, b=4: result 0x10 in cycle 5.
- Shift with b=0x20 (shamt 0): result = a in cycle 1.
- Result ready with `i_ready`=0 for 5 cycles: `o_valid`/`o_result` held constant and no new accept. When `i_ready` rises, the pending `i_valid` is accepted in the same cycle.
- `i_flush` mid-SLL (b=10, cycle 4): no `o_valid` for that op, `o_ready`=1 the next cycle. Async `i_rst_n` low mid-shift: `o_valid`=0 and `o_result`=0 immediately.
